// File: rtl/viterbi_ctl.sv
// Frame sequencer for the K=3 rate-1/2 Viterbi datapath: symbol capture, ACS/normalize
// stepping, then a fixed-length traceback, all driven from registered Moore outputs.
module viterbi_ctl #(
  parameter int FRAME_LEN   = 16,
  parameter int AW          = 4,
  parameter int NORM_PERIOD = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          sym_valid,
  output logic          sym_ready,
  input  logic          cx0,
  input  logic          cx1,
  output logic          bmu_cx0,
  output logic          bmu_cx1,
  output logic          acs_init,
  output logic          acs_en,
  output logic          norm_en,
  output logic          sm_wr_en,
  output logic [AW-1:0] sm_addr,
  output logic          tb_start,
  output logic          tb_en,
  output logic          busy,
  output logic          frame_done
);

  localparam int NW = (NORM_PERIOD > 1) ? $clog2(NORM_PERIOD) : 1;

  typedef enum logic [2:0] {
    IDLE, INIT, WAIT_SYM, ACS, NORM, TRACE, DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] step_cnt;
  logic [NW-1:0] norm_cnt;
  logic          last_step;
  logic          norm_wrap;

  assign last_step = (step_cnt == AW'(FRAME_LEN - 1));
  assign norm_wrap = (norm_cnt == NW'(NORM_PERIOD - 1));

  // Outputs are loaded together with the next state, so each reflects the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      step_cnt   <= '0;
      norm_cnt   <= '0;
      sym_ready  <= 1'b0;
      bmu_cx0    <= 1'b0;
      bmu_cx1    <= 1'b0;
      acs_init   <= 1'b0;
      acs_en     <= 1'b0;
      norm_en    <= 1'b0;
      sm_wr_en   <= 1'b0;
      sm_addr    <= '0;
      tb_start   <= 1'b0;
      tb_en      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      acs_init   <= 1'b0;
      acs_en     <= 1'b0;
      norm_en    <= 1'b0;
      sm_wr_en   <= 1'b0;
      tb_start   <= 1'b0;
      tb_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= INIT;
            acs_init <= 1'b1;
            busy     <= 1'b1;
            step_cnt <= '0;
            norm_cnt <= '0;
          end
        end
        INIT: begin
          state     <= WAIT_SYM;
          sym_ready <= 1'b1;
        end
        WAIT_SYM: begin
          if (sym_valid) begin
            bmu_cx0   <= cx0;
            bmu_cx1   <= cx1;
            state     <= ACS;
            sym_ready <= 1'b0;
            acs_en    <= 1'b1;
            sm_wr_en  <= 1'b1;
            sm_addr   <= step_cnt;
          end
        end
        ACS: begin
          if (norm_wrap) begin
            norm_cnt <= '0;
            state    <= NORM;
            norm_en  <= 1'b1;
          end else begin
            norm_cnt <= norm_cnt + NW'(1);
            if (last_step) begin
              state    <= TRACE;
              sm_addr  <= AW'(FRAME_LEN - 1);
              tb_en    <= 1'b1;
              tb_start <= 1'b1;
            end else begin
              step_cnt  <= step_cnt + AW'(1);
              state     <= WAIT_SYM;
              sym_ready <= 1'b1;
            end
          end
        end
        NORM: begin
          if (last_step) begin
            state    <= TRACE;
            sm_addr  <= AW'(FRAME_LEN - 1);
            tb_en    <= 1'b1;
            tb_start <= 1'b1;
          end else begin
            step_cnt  <= step_cnt + AW'(1);
            state     <= WAIT_SYM;
            sym_ready <= 1'b1;
          end
        end
        TRACE: begin
          if (sm_addr == '0) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else begin
            sm_addr <= sm_addr - AW'(1);
            tb_en   <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          sm_addr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_ctl.sv
// Directed bench for viterbi_ctl: walks each frame cycle by cycle against a hand-written timeline.
module tb_viterbi_ctl;

  logic       clk = 1'b0;
  logic       reset, start, sym_valid, cx0, cx1;
  logic       sym_ready, bmu_cx0, bmu_cx1, acs_init, acs_en, norm_en, sm_wr_en;
  logic [3:0] sm_addr;
  logic       tb_start, tb_en, busy, frame_done;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [1:0] last_sym;

  viterbi_ctl dut (
    .clk(clk), .reset(reset), .start(start), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .cx0(cx0), .cx1(cx1), .bmu_cx0(bmu_cx0), .bmu_cx1(bmu_cx1), .acs_init(acs_init),
    .acs_en(acs_en), .norm_en(norm_en), .sm_wr_en(sm_wr_en), .sm_addr(sm_addr),
    .tb_start(tb_start), .tb_en(tb_en), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {busy, sym_ready, acs_init, acs_en, norm_en, sm_wr_en, sm_addr,
              tb_start, tb_en, frame_done, bmu_cx1, bmu_cx0}, 32'h0);
  endtask

  // stall_at: symbol index whose WAIT_SYM is held 5 extra cycles (-1 none)
  // poke: pulse start in WAIT_SYM and TRACE, feed a differing symbol during TRACE
  // abort_addr: assert reset mid-cycle when traceback shows this address (-1 none)
  task automatic run_frame(input int stall_at, input bit poke, input int abort_addr);
    int cyc;
    start = 1'b1;
    tick; cyc = 1;
    start = 1'b0;
    chk("init_pulse", acs_init, 1);
    chk("init_busy", busy, 1);
    chk("init_ready", sym_ready, 0);
    for (int i = 0; i < 16; i++) begin
      tick; cyc++;
      if (i == stall_at) begin
        sym_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick; cyc++;
          chk("stall_ready", sym_ready, 1);
          chk("stall_acs", {acs_en, sm_wr_en}, 0);
        end
      end
      chk("wait_ready", sym_ready, 1);
      chk("wait_no_acs", {acs_init, acs_en, sm_wr_en, norm_en}, 0);
      chk("wait_bmu_hold", {bmu_cx1, bmu_cx0}, last_sym);
      if (poke && i == 5) start = 1'b1;
      {cx1, cx0} = 2'(i % 4);
      sym_valid = 1'b1;
      tick; cyc++;
      start = 1'b0;
      chk("acs_pulse", {acs_en, sm_wr_en}, 2'b11);
      chk("acs_addr", sm_addr, i);
      chk("acs_bmu", {bmu_cx1, bmu_cx0}, i % 4);
      chk("acs_others", {acs_init, norm_en, tb_en, sym_ready}, 0);
      last_sym = 2'(i % 4);
      {cx1, cx0} = ~last_sym;
      if (i % 4 == 3) begin
        tick; cyc++;
        chk("norm_pulse", norm_en, 1);
        chk("norm_others", {acs_en, sm_wr_en, acs_init, tb_en, sym_ready}, 0);
      end
    end
    for (int t = 0; t < 16; t++) begin
      tick; cyc++;
      chk("tr_en", tb_en, 1);
      chk("tr_start", tb_start, (t == 0));
      chk("tr_addr", sm_addr, 15 - t);
      chk("tr_others", {sm_wr_en, acs_en, acs_init, norm_en, sym_ready, frame_done}, 0);
      chk("tr_bmu_hold", {bmu_cx1, bmu_cx0}, last_sym);
      if (poke && t == 3) begin
        start = 1'b1;
        sym_valid = 1'b1;
        {cx1, cx0} = ~last_sym;
      end
      if (poke && t == 4) start = 1'b0;
      if (15 - t == abort_addr) begin
        #2 reset = 1'b1;
        #1 chk_zero("abort_zero");
        @(negedge clk);
        reset = 1'b0;
        sym_valid = 1'b0;
        last_sym = 2'b00;
        for (int k = 0; k < 4; k++) begin
          tick;
          chk("abort_no_done", frame_done, 0);
          chk("abort_idle", busy, 0);
        end
        return;
      end
    end
    tick; cyc++;
    chk("done_pulse", frame_done, 1);
    chk("done_cycle", cyc, (stall_at >= 0) ? 59 : 54);
    chk("done_no_tb", {tb_en, tb_start}, 0);
    tick;
    chk("idle_busy", busy, 0);
    chk("idle_done", frame_done, 0);
    chk("idle_addr", sm_addr, 0);
    tick;
    chk("idle_stays", {busy, acs_init}, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sym_valid = 1'b0; cx0 = 1'b0; cx1 = 1'b0;
    last_sym = 2'b00;
    tick;
    chk_zero("reset_zero");
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("post_reset_busy", busy, 0);
    end
    run_frame(-1, 1'b0, -1);
    run_frame(3, 1'b1, -1);
    run_frame(-1, 1'b0, 7);
    run_frame(-1, 1'b0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
